// File: rtl/mem_port_arb.sv
// -----------------------------------------------------------------------------
// mem_port_arb
//
// Arbitrates the single data port of the shared RAM between the CPU and a
// loader. The CPU owns the port by default. A loader request holds the CPU in
// reset, waits DRAIN_CYC cycles for in-flight CPU traffic to settle, and then
// grants the port to the loader. When the loader lets go, the CPU stays in
// reset for REL_CYC more cycles before it runs again.
//
// Ports
//   CLK          system clock, rising edge
//   rst          synchronous active-high reset
//   cpu_addr_i   CPU byte address            cpu_dout_i   CPU write data
//   cpu_wr_en_i  CPU byte write enables      cpu_din_o    read data to the CPU
//   cpu_rst_o    reset request to the core
//   ldr_req_i    loader ownership request (level)
//   ldr_addr_i   loader byte address         ldr_data_i   loader write data
//   ldr_wr_i     loader write strobe         ldr_gnt_o    loader owns the port
//   ldr_ack_o    pulse: previous-cycle loader write was committed
//   ldr_err_o    sticky: loader address was out of range
//   ldr_cnt_o    words committed in the current load session (saturating)
//   mem_addr_o   RAM address                 mem_din_o    RAM write data
//   mem_wren_o   RAM byte write enables      mem_dout_i   RAM read data (1-cycle)
// -----------------------------------------------------------------------------
module mem_port_arb #(
    parameter int MEM_WORDS = 2048,
    parameter int DRAIN_CYC = 4,
    parameter int REL_CYC   = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_dout_i,
    input  logic [3:0]  cpu_wr_en_i,
    output logic [31:0] cpu_din_o,
    output logic        cpu_rst_o,
    input  logic        ldr_req_i,
    input  logic [31:0] ldr_addr_i,
    input  logic [31:0] ldr_data_i,
    input  logic        ldr_wr_i,
    output logic        ldr_gnt_o,
    output logic        ldr_ack_o,
    output logic        ldr_err_o,
    output logic [15:0] ldr_cnt_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_din_o,
    output logic [3:0]  mem_wren_o,
    input  logic [31:0] mem_dout_i
);

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
    localparam logic [15:0] DRAIN_LD  = 16'(DRAIN_CYC);
    localparam logic [15:0] REL_LD    = 16'(REL_CYC);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        ldr_in_range;
    logic        ldr_commit;

    // Loader address range check and the condition for a committed RAM write.
    // The low two address bits never take part: loader writes are whole words.
    // A write is suppressed while the request is dropping and during reset.
    always_comb begin
        ldr_in_range = ({2'b00, ldr_addr_i[31:2]} < MEM_LIMIT);
        ldr_commit   = (state == ST_LOAD) && ldr_req_i && ldr_wr_i &&
                       ldr_in_range && !rst;
    end

    // RAM port mux: CPU pass-through in CPU state, loader in LOAD, and no
    // write enable at all while the port is changing hands.
    always_comb begin
        mem_addr_o = cpu_addr_i;
        mem_din_o  = cpu_dout_i;
        mem_wren_o = 4'b0000;
        cpu_din_o  = 32'h0000_0000;
        case (state)
            ST_CPU: begin
                mem_wren_o = cpu_wr_en_i;
                cpu_din_o  = mem_dout_i;
            end
            ST_LOAD: begin
                mem_addr_o = ldr_addr_i;
                mem_din_o  = ldr_data_i;
                mem_wren_o = ldr_commit ? 4'b1111 : 4'b0000;
            end
            default: begin
                mem_wren_o = 4'b0000;
                cpu_din_o  = 32'h0000_0000;
            end
        endcase
    end

    // Ownership FSM with registered status outputs. wait_cnt is shared by the
    // DRAIN and RELEASE waits; leaving when it is at 1 (or 0 for a zero-length
    // parameter) makes each wait last exactly its parameter in cycles.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= ST_CPU;
            wait_cnt  <= 16'd0;
            cpu_rst_o <= 1'b0;
            ldr_gnt_o <= 1'b0;
            ldr_ack_o <= 1'b0;
            ldr_err_o <= 1'b0;
            ldr_cnt_o <= 16'd0;
        end else begin
            ldr_ack_o <= 1'b0;
            case (state)
                ST_CPU: begin
                    ldr_gnt_o <= 1'b0;
                    if (ldr_req_i) begin
                        state     <= ST_DRAIN;
                        wait_cnt  <= DRAIN_LD;
                        cpu_rst_o <= 1'b1;
                    end else begin
                        cpu_rst_o <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    cpu_rst_o <= 1'b1;
                    if (!ldr_req_i) begin
                        // Request withdrawn before the grant: hand back.
                        state    <= ST_RELEASE;
                        wait_cnt <= REL_LD;
                    end else if (wait_cnt <= 16'd1) begin
                        state     <= ST_LOAD;
                        wait_cnt  <= 16'd0;
                        ldr_gnt_o <= 1'b1;
                        ldr_cnt_o <= 16'd0;
                        ldr_err_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                ST_LOAD: begin
                    cpu_rst_o <= 1'b1;
                    if (!ldr_req_i) begin
                        state     <= ST_RELEASE;
                        wait_cnt  <= REL_LD;
                        ldr_gnt_o <= 1'b0;
                    end else if (ldr_wr_i) begin
                        if (ldr_in_range) begin
                            ldr_ack_o <= 1'b1;
                            if (ldr_cnt_o != 16'hFFFF) begin
                                ldr_cnt_o <= ldr_cnt_o + 16'd1;
                            end else begin
                                ldr_cnt_o <= ldr_cnt_o;
                            end
                        end else begin
                            ldr_err_o <= 1'b1;
                        end
                    end else begin
                        ldr_cnt_o <= ldr_cnt_o;
                    end
                end
                ST_RELEASE: begin
                    // Loader request is deliberately not looked at here.
                    if (wait_cnt <= 16'd1) begin
                        state     <= ST_CPU;
                        wait_cnt  <= 16'd0;
                        cpu_rst_o <= 1'b0;
                    end else begin
                        wait_cnt  <= wait_cnt - 16'd1;
                        cpu_rst_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_CPU;
                    wait_cnt  <= 16'd0;
                    cpu_rst_o <= 1'b0;
                    ldr_gnt_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
`timescale 1ns/1ps
module tb_mem_port_arb;

    localparam int MW = 2048;
    localparam int DC = 4;
    localparam int RC = 2;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr_i = 32'd0;
    logic [31:0] cpu_dout_i = 32'd0;
    logic [3:0]  cpu_wr_en_i = 4'd0;
    logic [31:0] cpu_din_o;
    logic        cpu_rst_o;
    logic        ldr_req_i = 1'b0;
    logic [31:0] ldr_addr_i = 32'd0;
    logic [31:0] ldr_data_i = 32'd0;
    logic        ldr_wr_i = 1'b0;
    logic        ldr_gnt_o;
    logic        ldr_ack_o;
    logic        ldr_err_o;
    logic [15:0] ldr_cnt_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_din_o;
    logic [3:0]  mem_wren_o;
    logic [31:0] mem_dout_i = 32'd0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    mem_port_arb #(.MEM_WORDS(MW), .DRAIN_CYC(DC), .REL_CYC(RC)) dut (
        .CLK(CLK), .rst(rst),
        .cpu_addr_i(cpu_addr_i), .cpu_dout_i(cpu_dout_i), .cpu_wr_en_i(cpu_wr_en_i),
        .cpu_din_o(cpu_din_o), .cpu_rst_o(cpu_rst_o),
        .ldr_req_i(ldr_req_i), .ldr_addr_i(ldr_addr_i), .ldr_data_i(ldr_data_i),
        .ldr_wr_i(ldr_wr_i), .ldr_gnt_o(ldr_gnt_o), .ldr_ack_o(ldr_ack_o),
        .ldr_err_o(ldr_err_o), .ldr_cnt_o(ldr_cnt_o),
        .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_wren_o(mem_wren_o),
        .mem_dout_i(mem_dout_i)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Bench RAM: byte enables, write-first read data one cycle after address.
    logic [31:0] ram [0:MW-1];
    always @(posedge CLK) begin
        logic [31:0] w;
        int idx;
        idx = int'(mem_addr_o[12:2]);
        w = ram[idx];
        for (int b = 0; b < 4; b++)
            if (mem_wren_o[b]) w[8*b +: 8] = mem_din_o[8*b +: 8];
        ram[idx]   <= w;
        mem_dout_i <= w;
    end

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_DRAIN, P_LOAD, P_REL} phase_t;
    phase_t      m_phase = P_IDLE;
    int          m_elapsed = 0;
    int          m_cnt = 0;
    bit          m_rst = 0, m_gnt = 0, m_ack = 0, m_err = 0;
    bit          m_rd_valid = 0;
    logic [31:0] m_rd = 32'd0;
    logic [31:0] m_mem [0:MW-1];

    function automatic bit in_range(input logic [31:0] a);
        return ({2'b00, a[31:2]} < 32'(MW));
    endfunction

    function automatic logic [3:0] exp_wren();
        if (m_phase == P_IDLE) return cpu_wr_en_i;
        if (m_phase == P_LOAD)
            return (ldr_req_i && ldr_wr_i && in_range(ldr_addr_i) && !rst) ? 4'hF : 4'h0;
        return 4'h0;
    endfunction

    // Model: who owns the port, how long each wait has run, and the RAM image.
    always @(posedge CLK) begin
        logic [3:0]  we;
        logic [31:0] a, d, w;
        int idx;
        we  = exp_wren();
        a   = (m_phase == P_LOAD) ? ldr_addr_i : cpu_addr_i;
        d   = (m_phase == P_LOAD) ? ldr_data_i : cpu_dout_i;
        idx = int'(a[12:2]);
        w   = m_mem[idx];
        for (int b = 0; b < 4; b++)
            if (we[b]) w[8*b +: 8] = d[8*b +: 8];
        m_mem[idx] <= w;
        m_rd       <= w;
        m_rd_valid <= chk_en && (m_phase == P_IDLE);
        if (rst) begin
            m_phase <= P_IDLE; m_elapsed <= 0; m_cnt <= 0;
            m_rst <= 0; m_gnt <= 0; m_ack <= 0; m_err <= 0;
        end else begin
            m_ack <= 0;
            case (m_phase)
                P_IDLE: if (ldr_req_i) begin
                    m_phase <= P_DRAIN; m_elapsed <= 0; m_rst <= 1;
                end
                P_DRAIN: if (!ldr_req_i) begin
                    m_phase <= P_REL; m_elapsed <= 0;
                end else if (m_elapsed + 1 >= DC) begin
                    m_phase <= P_LOAD; m_gnt <= 1; m_cnt <= 0; m_err <= 0;
                end else m_elapsed <= m_elapsed + 1;
                P_LOAD: if (!ldr_req_i) begin
                    m_phase <= P_REL; m_gnt <= 0; m_elapsed <= 0;
                end else if (ldr_wr_i) begin
                    if (in_range(ldr_addr_i)) begin
                        m_ack <= 1;
                        m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                    end else m_err <= 1;
                end
                default: if (m_elapsed + 1 >= RC) begin
                    m_phase <= P_IDLE; m_rst <= 0;
                end else m_elapsed <= m_elapsed + 1;
            endcase
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cpu_rst", {31'd0, cpu_rst_o}, {31'd0, m_rst});
            chk("gnt", {31'd0, ldr_gnt_o}, {31'd0, m_gnt});
            chk("ack", {31'd0, ldr_ack_o}, {31'd0, m_ack});
            chk("err", {31'd0, ldr_err_o}, {31'd0, m_err});
            chk("cnt", {16'd0, ldr_cnt_o}, 32'(m_cnt));
            chk("mem_wren", {28'd0, mem_wren_o}, {28'd0, exp_wren()});
            if (m_phase == P_IDLE) begin
                chk("cpu_addr_pass", mem_addr_o, cpu_addr_i);
                chk("cpu_data_pass", mem_din_o, cpu_dout_i);
                if (m_rd_valid) chk("cpu_din", cpu_din_o, m_rd);
            end else if (m_phase == P_LOAD) begin
                chk("ldr_addr_pass", mem_addr_o, ldr_addr_i);
                chk("ldr_data_pass", mem_din_o, ldr_data_i);
                chk("cpu_din_load", cpu_din_o, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] data_a [8];
    logic [31:0] data_b [8];
    logic [31:0] saved;
    int n, acks, diffs;

    initial begin
        for (int i = 0; i < MW; i++) begin
            ram[i]   = 32'd0;
            m_mem[i] = 32'd0;
        end
        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
        chk("rst_gnt", {31'd0, ldr_gnt_o}, 32'd0);
        chk("rst_cnt", {16'd0, ldr_cnt_o}, 32'd0);

        // Idle pass-through
        cpu_addr_i = 32'h10; cpu_dout_i = 32'hDEADBEEF; cpu_wr_en_i = 4'b0011;
        #1;
        chk("pt_addr", mem_addr_o, 32'h10);
        chk("pt_data", mem_din_o, 32'hDEADBEEF);
        chk("pt_wren", {28'd0, mem_wren_o}, 32'h3);
        tick();
        cpu_wr_en_i = 4'b0000;
        #1;
        chk("pt_read", cpu_din_o, 32'h0000BEEF);

        // Some random CPU traffic
        for (int i = 0; i < 40; i++) begin
            tick();
            cpu_addr_i  = {19'd0, 13'($urandom)};
            cpu_dout_i  = $urandom;
            cpu_wr_en_i = 4'($urandom);
        end
        tick();
        cpu_wr_en_i = 4'b0000;

        // Grant sequence
        ldr_req_i = 1'b1;
        tick();
        chk("grant_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        n = 1;
        while (!ldr_gnt_o && n < 20) begin tick(); n++; end
        chk("grant_latency", 32'(n), 32'd5);

        // Load burst with CPU write enables asserted (must be ignored)
        acks = 0;
        cpu_wr_en_i = 4'hF; cpu_addr_i = 32'h100; cpu_dout_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            data_a[i] = $urandom;
            ldr_addr_i = 32'(i * 4); ldr_data_i = data_a[i]; ldr_wr_i = 1'b1;
            tick();
            acks += int'(ldr_ack_o);
        end
        ldr_wr_i = 1'b0;
        tick();
        acks += int'(ldr_ack_o);
        chk("burst_acks", 32'(acks), 32'd8);
        chk("burst_cnt", {16'd0, ldr_cnt_o}, 32'd8);
        for (int i = 0; i < 8; i++) chk("burst_ram", ram[i], data_a[i]);
        chk("burst_cpu_ignored", ram[64], 32'd0);

        // Range check
        ldr_addr_i = 32'h2000; ldr_data_i = 32'h5555_AAAA; ldr_wr_i = 1'b1;
        #1;
        chk("range_wren", {28'd0, mem_wren_o}, 32'd0);
        tick();
        ldr_wr_i = 1'b0;
        chk("range_err", {31'd0, ldr_err_o}, 32'd1);
        chk("range_ack", {31'd0, ldr_ack_o}, 32'd0);
        chk("range_cnt", {16'd0, ldr_cnt_o}, 32'd8);

        // Release with a simultaneous write strobe
        cpu_wr_en_i = 4'h0;
        saved = ram[16];
        ldr_addr_i = 32'h40; ldr_data_i = 32'h1234_5678; ldr_wr_i = 1'b1; ldr_req_i = 1'b0;
        #1;
        chk("rel_wren", {28'd0, mem_wren_o}, 32'd0);
        tick();
        ldr_wr_i = 1'b0;
        chk("rel_gnt", {31'd0, ldr_gnt_o}, 32'd0);
        n = 0;
        while (cpu_rst_o && n < 20) begin tick(); n++; end
        chk("rel_cycles", 32'(n), 32'(RC));
        chk("rel_ram", ram[16], saved);

        // Mid-load reset during the fifth write
        ldr_req_i = 1'b1;
        n = 0;
        while (!ldr_gnt_o && n < 20) begin tick(); n++; end
        chk("regrant", {31'd0, ldr_gnt_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            data_b[i] = $urandom;
            ldr_addr_i = 32'(i * 4); ldr_data_i = data_b[i]; ldr_wr_i = 1'b1;
            tick();
        end
        ldr_addr_i = 32'h10; ldr_data_i = 32'hCAFE_F00D; rst = 1'b1;
        #1;
        chk("midrst_wren", {28'd0, mem_wren_o}, 32'd0);
        tick();
        rst = 1'b0; ldr_req_i = 1'b0; ldr_wr_i = 1'b0;
        chk("midrst_gnt", {31'd0, ldr_gnt_o}, 32'd0);
        chk("midrst_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
        chk("midrst_cnt", {16'd0, ldr_cnt_o}, 32'd0);
        chk("midrst_ack", {31'd0, ldr_ack_o}, 32'd0);
        for (int i = 0; i < 4; i++) chk("midrst_ram", ram[i], data_b[i]);
        chk("midrst_word4", ram[4], data_a[4]);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            tick();
            if ($urandom_range(0, 15) == 0) ldr_req_i = ~ldr_req_i;
            ldr_wr_i    = 1'($urandom_range(0, 1));
            ldr_addr_i  = 32'($urandom_range(0, 32'h23FF));
            ldr_data_i  = $urandom;
            cpu_addr_i  = {19'd0, 13'($urandom)};
            cpu_dout_i  = $urandom;
            cpu_wr_en_i = 4'($urandom);
            rst         = ($urandom_range(0, 199) == 0);
        end
        tick();
        rst = 1'b0; ldr_req_i = 1'b0; ldr_wr_i = 1'b0; cpu_wr_en_i = 4'h0;
        tick();
        diffs = 0;
        for (int i = 0; i < MW; i++) if (ram[i] !== m_mem[i]) diffs++;
        chk("ram_image", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
